// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - funct codes, FSM state type and op classification for alu_md_seq
// Contents:
//   F_*      MIPS R-type funct codes handled by the ALU
//   state_t  sequencer states (IDLE, ITER, FIX, DONE)
//   is_md()  true for funct codes that run on the iterative mul/div engine
// Macro ALU_MD_DIV_EN: when defined, div/divu are multi-cycle ops; otherwise they are illegal.
package alu_pkg;

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_SRA   = 6'd3;
    localparam logic [5:0] F_JR    = 6'd8;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_XOR   = 6'd38;
    localparam logic [5:0] F_NOR   = 6'd39;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SLTU  = 6'd43;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic is_md(input logic [5:0] op);
`ifdef ALU_MD_DIV_EN
        return (op == F_MULT) || (op == F_MULTU) || (op == F_DIV) || (op == F_DIVU);
`else
        return (op == F_MULT) || (op == F_MULTU);
`endif
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// rtl/alu_md_iter.sv - iterative shift-add multiplier / restoring divider on operand magnitudes
// Ports:
//   clk, rst         clock, synchronous active-high reset (abandons any operation)
//   start            load operands and begin WIDTH iterations
//   sign_en          treat a/b as signed; the engine works on their magnitudes
//   div_sel          divide instead of multiply (only with ALU_MD_DIV_EN)
//   a, b             multiplicand/multiplier or dividend/divisor
//   mag_hi, mag_lo   magnitude product {hi,lo}, or remainder (hi) / quotient (lo)
//   done             high during the last iteration; results are final the cycle after
// Macro ALU_MD_DIV_EN: when undefined the divider datapath and div_sel are omitted.
module alu_md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign_en,
`ifdef ALU_MD_DIV_EN
    input  logic             div_sel,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] mag_hi,
    output logic [WIDTH-1:0] mag_lo,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc;      // product high half or partial remainder
    logic [WIDTH-1:0] shreg;    // multiplier bits shifting out / quotient bits shifting in
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] nxt_acc;
    logic [WIDTH-1:0] nxt_sh;
`ifdef ALU_MD_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
`endif

    // The most-negative value maps to itself, which is its correct unsigned magnitude.
    assign a_mag = (sign_en && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sign_en && b[WIDTH-1]) ? -b : b;

    always_comb begin
        mul_sum = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
        nxt_acc = mul_sum[WIDTH:1];
        nxt_sh  = {mul_sum[0], shreg[WIDTH-1:1]};
`ifdef ALU_MD_DIV_EN
        div_shift = {acc, shreg[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd};
        if (div_q) begin
            // A zero divisor never restores: quotient all ones, remainder = dividend.
            if (!div_trial[WIDTH]) begin
                nxt_acc = div_trial[WIDTH-1:0];
                nxt_sh  = {shreg[WIDTH-2:0], 1'b1};
            end else begin
                nxt_acc = div_shift[WIDTH-1:0];
                nxt_sh  = {shreg[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            opnd  <= '0;
            acc   <= '0;
            shreg <= '0;
`ifdef ALU_MD_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            acc  <= '0;
`ifdef ALU_MD_DIV_EN
            div_q <= div_sel;
            if (div_sel) begin
                shreg <= a_mag;
                opnd  <= b_mag;
            end else begin
                shreg <= b_mag;
                opnd  <= a_mag;
            end
`else
            shreg <= b_mag;
            opnd  <= a_mag;
`endif
        end else if (busy) begin
            acc   <= nxt_acc;
            shreg <= nxt_sh;
            cnt   <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

    assign done   = busy && (cnt == CNT_W'(WIDTH - 1));
    assign mag_hi = acc;
    assign mag_lo = shreg;

endmodule

// File: rtl/alu_md_seq.sv
// rtl/alu_md_seq.sv - registered MIPS R-type ALU with HI/LO and iterative mul/div
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         request handshake; in_ready high only in IDLE
//   op, shamt, reg_one, reg_two funct code, shift amount, rs and rt operands
//   out_valid                   one-cycle pulse when result and flags are valid
//   result                      registered result (LO for mul/div)
//   zero_f, negative_f          result zero / true sign of the operation
//   overflow_f, carry_f         signed overflow / carry or borrow
//   illegal_f                   unsupported funct code
//   hi_q, lo_q                  HI and LO registers
// Macro ALU_MD_DIV_EN: enables div/divu; without it funct 26/27 are illegal.
module alu_md_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   reg_one,
    input  logic [WIDTH-1:0]   reg_two,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic               zero_f,
    output logic               negative_f,
    output logic               overflow_f,
    output logic               carry_f,
    output logic               illegal_f,
    output logic [WIDTH-1:0]   hi_q,
    output logic [WIDTH-1:0]   lo_q
);

    state_t state, state_next;

    logic             md_op;
    logic             eng_start;
    logic             eng_done;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;

    logic             md_signed_q;
    logic             a_neg_q;
    logic             b_neg_q;
`ifdef ALU_MD_DIV_EN
    logic             md_div_q;
    logic             b_zero_q;
    logic [WIDTH-1:0] a_q;
`endif

    assign md_op     = is_md(op);
    assign eng_start = in_valid && in_ready && md_op;

    alu_md_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .start   (eng_start),
        .sign_en (~op[0]),
`ifdef ALU_MD_DIV_EN
        .div_sel (op[1]),
`endif
        .a       (reg_one),
        .b       (reg_two),
        .mag_hi  (eng_hi),
        .mag_lo  (eng_lo),
        .done    (eng_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = md_op ? S_ITER : S_DONE;
            end
            S_ITER:  if (eng_done) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE: begin
                out_valid  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Single-cycle ALU, evaluated on the accept cycle.
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             sub_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_cry;
    logic             alu_neg;
    logic             alu_ill;
    logic             arith;
    logic             arith_neg;

    assign sum     = {1'b0, reg_one} + {1'b0, reg_two};
    assign diff    = {1'b0, reg_one} - {1'b0, reg_two};
    assign sub_ovf = (reg_one[WIDTH-1] != reg_two[WIDTH-1]) && (diff[WIDTH-1] != reg_one[WIDTH-1]);

    always_comb begin
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_cry   = 1'b0;
        alu_ill   = 1'b0;
        arith     = 1'b0;
        arith_neg = 1'b0;
        case (op)
            F_SLL:  alu_res = reg_one << shamt;
            F_SRL:  alu_res = reg_one >> shamt;
            F_SRA:  alu_res = $signed(reg_one) >>> shamt;
            F_JR:   alu_res = reg_one;
            F_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_cry   = sum[WIDTH];
                alu_ovf   = (reg_one[WIDTH-1] == reg_two[WIDTH-1]) && (sum[WIDTH-1] != reg_one[WIDTH-1]);
                arith     = 1'b1;
                arith_neg = sum[WIDTH-1] ^ alu_ovf;
            end
            F_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_cry   = diff[WIDTH];
                alu_ovf   = sub_ovf;
                arith     = 1'b1;
                arith_neg = diff[WIDTH-1] ^ sub_ovf;
            end
            F_AND:  alu_res = reg_one & reg_two;
            F_OR:   alu_res = reg_one | reg_two;
            F_XOR:  alu_res = reg_one ^ reg_two;
            F_NOR:  alu_res = ~(reg_one | reg_two);
            F_SLT: begin
                alu_res   = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
                alu_cry   = diff[WIDTH];
                alu_ovf   = sub_ovf;
                arith     = 1'b1;
                arith_neg = diff[WIDTH-1] ^ sub_ovf;
            end
            F_SLTU: begin
                alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
                alu_cry = diff[WIDTH];
            end
            F_MFHI: alu_res = hi_q;
            F_MFLO: alu_res = lo_q;
            F_MTHI, F_MTLO: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
        alu_neg = arith ? arith_neg : alu_res[WIDTH-1];
    end

    // Sign correction of the engine's magnitude results.
    logic [2*WIDTH-1:0] prod_mag;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign prod_mag = {eng_hi, eng_lo};

    always_comb begin
        {fix_hi, fix_lo} = (md_signed_q && (a_neg_q ^ b_neg_q)) ? -prod_mag : prod_mag;
`ifdef ALU_MD_DIV_EN
        if (md_div_q) begin
            if (b_zero_q) begin
                fix_hi = a_q;
                fix_lo = '1;
            end else begin
                fix_lo = (md_signed_q && (a_neg_q ^ b_neg_q)) ? -eng_lo : eng_lo;
                fix_hi = (md_signed_q && a_neg_q) ? -eng_hi : eng_hi;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result      <= '0;
            zero_f      <= 1'b0;
            negative_f  <= 1'b0;
            overflow_f  <= 1'b0;
            carry_f     <= 1'b0;
            illegal_f   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            md_signed_q <= 1'b0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
`ifdef ALU_MD_DIV_EN
            md_div_q    <= 1'b0;
            b_zero_q    <= 1'b0;
            a_q         <= '0;
`endif
        end else begin
            if (state == S_IDLE && in_valid) begin
                if (md_op) begin
                    md_signed_q <= ~op[0];
                    a_neg_q     <= reg_one[WIDTH-1];
                    b_neg_q     <= reg_two[WIDTH-1];
`ifdef ALU_MD_DIV_EN
                    md_div_q    <= op[1];
                    b_zero_q    <= (reg_two == '0);
                    a_q         <= reg_one;
`endif
                end else begin
                    result     <= alu_res;
                    zero_f     <= (alu_res == '0);
                    negative_f <= alu_neg;
                    overflow_f <= alu_ovf;
                    carry_f    <= alu_cry;
                    illegal_f  <= alu_ill;
                    if (op == F_MTHI) hi_q <= reg_one;
                    if (op == F_MTLO) lo_q <= reg_one;
                end
            end
            if (state == S_FIX) begin
                hi_q       <= fix_hi;
                lo_q       <= fix_lo;
                result     <= fix_lo;
                zero_f     <= (fix_lo == '0);
                negative_f <= fix_lo[WIDTH-1];
                overflow_f <= 1'b0;
                carry_f    <= 1'b0;
                illegal_f  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_md_seq.sv
// tb/tb_alu_md_seq.sv - directed self-checking bench for alu_md_seq (WIDTH=32)
module tb_alu_md_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  op;
    logic [4:0]  shamt;
    logic [31:0] reg_one;
    logic [31:0] reg_two;
    logic        out_valid;
    logic [31:0] result;
    logic        zero_f;
    logic        negative_f;
    logic        overflow_f;
    logic        carry_f;
    logic        illegal_f;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    int checks = 0;
    int errors = 0;
    int lat;
    int ready_seen;
    int pulses;

    always #5 clk = ~clk;

    alu_md_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .shamt      (shamt),
        .reg_one    (reg_one),
        .reg_two    (reg_two),
        .out_valid  (out_valid),
        .result     (result),
        .zero_f     (zero_f),
        .negative_f (negative_f),
        .overflow_f (overflow_f),
        .carry_f    (carry_f),
        .illegal_f  (illegal_f),
        .hi_q       (hi_q),
        .lo_q       (lo_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at #1 after a rising edge. Issues one op and returns at #1 after the
    // edge where out_valid is seen; lat counts edges from the accept edge (accept = 1).
    task automatic run_op(input logic [5:0] o, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b,
                          output int latency, output int rdy);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        op = o; shamt = sh; reg_one = a; reg_two = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        latency = 1;
        rdy = 0;
        while (!out_valid && latency < 100) begin
            if (in_ready) rdy++;
            @(posedge clk); #1;
            latency++;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; shamt = '0; reg_one = '0; reg_two = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_hi", hi_q, 32'd0);
        chk("rst_lo", lo_q, 32'd0);
        chk("rst_flags", {27'd0, zero_f, negative_f, overflow_f, carry_f, illegal_f}, 32'd0);

        run_op(6'd32, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, lat, ready_seen);
        chk("add_lat", lat, 32'd1);
        chk("add_res", result, 32'h8000_0000);
        chk("add_flags_zncv", {28'd0, zero_f, negative_f, overflow_f, carry_f}, 32'b0010);
        @(posedge clk); #1;
        chk("add_pulse_once", {31'd0, out_valid}, 32'd0);

        run_op(6'd34, 5'd0, 32'd5, 32'd7, lat, ready_seen);
        chk("sub_res", result, 32'hFFFF_FFFE);
        chk("sub_flags_zncv", {28'd0, zero_f, negative_f, overflow_f, carry_f}, 32'b0101);

        run_op(6'd42, 5'd0, 32'd5, 32'd7, lat, ready_seen);
        chk("slt_res", result, 32'd1);
        chk("slt_flags_zncv", {28'd0, zero_f, negative_f, overflow_f, carry_f}, 32'b0101);

        run_op(6'd43, 5'd0, 32'hFFFF_FFFF, 32'd1, lat, ready_seen);
        chk("sltu_res", result, 32'd0);
        chk("sltu_flags_zncv", {28'd0, zero_f, negative_f, overflow_f, carry_f}, 32'b1000);

        run_op(6'd24, 5'd0, 32'hFFFF_FFFD, 32'd7, lat, ready_seen);
        chk("mult_lat", lat, 32'd34);
        chk("mult_ready_low", ready_seen, 32'd0);
        chk("mult_hi", hi_q, 32'hFFFF_FFFF);
        chk("mult_lo", lo_q, 32'hFFFF_FFEB);
        chk("mult_res", result, 32'hFFFF_FFEB);
        chk("mult_neg", {31'd0, negative_f}, 32'd1);

        run_op(6'd16, 5'd0, 32'd0, 32'd0, lat, ready_seen);
        chk("mfhi_res", result, 32'hFFFF_FFFF);

        run_op(6'd25, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, ready_seen);
        chk("multu_hi", hi_q, 32'hFFFF_FFFE);
        chk("multu_lo", lo_q, 32'h0000_0001);

`ifdef ALU_MD_DIV_EN
        run_op(6'd26, 5'd0, 32'hFFFF_FFF9, 32'd2, lat, ready_seen);
        chk("div_lat", lat, 32'd34);
        chk("div_lo", lo_q, 32'hFFFF_FFFD);
        chk("div_hi", hi_q, 32'hFFFF_FFFF);

        run_op(6'd27, 5'd0, 32'd7, 32'd0, lat, ready_seen);
        chk("divu0_lat", lat, 32'd34);
        chk("divu0_hi", hi_q, 32'd7);
        chk("divu0_lo", lo_q, 32'hFFFF_FFFF);
        chk("divu0_illegal", {31'd0, illegal_f}, 32'd0);

        run_op(6'd26, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, lat, ready_seen);
        chk("divmin_lo", lo_q, 32'h8000_0000);
        chk("divmin_hi", hi_q, 32'd0);
`else
        run_op(6'd26, 5'd0, 32'hFFFF_FFF9, 32'd2, lat, ready_seen);
        chk("div_off_lat", lat, 32'd1);
        chk("div_off_illegal", {31'd0, illegal_f}, 32'd1);
        chk("div_off_res", result, 32'd0);
        chk("div_off_hi", hi_q, 32'hFFFF_FFFE);
        chk("div_off_lo", lo_q, 32'h0000_0001);
`endif

        run_op(6'd1, 5'd0, 32'h1234_5678, 32'h1, lat, ready_seen);
        chk("ill_res", result, 32'd0);
        chk("ill_flag", {31'd0, illegal_f}, 32'd1);

        run_op(6'd3, 5'd4, 32'h8000_0000, 32'd0, lat, ready_seen);
        chk("sra_res", result, 32'hF800_0000);
        chk("sra_illegal_clear", {31'd0, illegal_f}, 32'd0);
        run_op(6'd0, 5'd31, 32'h0000_0001, 32'd0, lat, ready_seen);
        chk("sll_res", result, 32'h8000_0000);
        run_op(6'd2, 5'd31, 32'h8000_0000, 32'd0, lat, ready_seen);
        chk("srl_res", result, 32'h0000_0001);

        run_op(6'd36, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, ready_seen);
        chk("and_res", result, 32'hF000_F000);
        run_op(6'd37, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, ready_seen);
        chk("or_res", result, 32'hFFF0_FFF0);
        run_op(6'd38, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, ready_seen);
        chk("xor_res", result, 32'h0FF0_0FF0);
        run_op(6'd39, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, ready_seen);
        chk("nor_res", result, 32'h000F_000F);
        run_op(6'd8, 5'd0, 32'hDEAD_BEEF, 32'd0, lat, ready_seen);
        chk("jr_res", result, 32'hDEAD_BEEF);

        run_op(6'd17, 5'd0, 32'h1234_5678, 32'd0, lat, ready_seen);
        chk("mthi_res", result, 32'd0);
        chk("mthi_hi", hi_q, 32'h1234_5678);
        run_op(6'd19, 5'd0, 32'h9ABC_DEF0, 32'd0, lat, ready_seen);
        chk("mtlo_lo", lo_q, 32'h9ABC_DEF0);
        run_op(6'd18, 5'd0, 32'd0, 32'd0, lat, ready_seen);
        chk("mflo_res", result, 32'h9ABC_DEF0);

        // Abandon a multu at its tenth iteration.
        @(posedge clk); #1;
        op = 6'd25; reg_one = 32'd3; reg_two = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_hi", hi_q, 32'd0);
        chk("abort_lo", lo_q, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) pulses++;
            @(posedge clk); #1;
        end
        chk("abort_no_pulse", pulses, 32'd0);

        run_op(6'd32, 5'd0, 32'd2, 32'd3, lat, ready_seen);
        chk("post_abort_add", result, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_md_seq.md
Name: alu_md_seq

Overview:
- Parametrised, registered successor to the single-cycle MIPS ALU.
- Executes all R-type funct operations: shifts, jr pass-through, add/sub, logic ops, slt, plus new sltu.
- Adds HI/LO registers and iterative mult/multu/div/divu behind a valid/ready handshake.
- Sits in the EX stage; the datapath stalls on in_ready low.

Parameters:
- WIDTH, 32: operand/result width; must be ≥4 and a power of two.
- SHAMT_W, $clog2(WIDTH): shift-amount width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high when IDLE
- op  in  6  MIPS funct code
- shamt  in  SHAMT_W  shift amount
- reg_one  in  WIDTH  rs operand
- reg_two  in  WIDTH  rt operand
- out_valid  out  1  one-cycle pulse, result/flags valid
- result  out  WIDTH  registered result
- zero_f  out  1  result == 0
- negative_f  out  1  true sign of operation
- overflow_f  out  1  signed overflow (add/sub/slt)
- carry_f  out  1  carry (add) / borrow (sub, slt, sltu)
- illegal_f  out  1  unsupported funct, valid with out_valid
- hi_q  out  WIDTH  HI register (debug/forwarding)
- lo_q  out  WIDTH  LO register

Behaviour:
- Reset (sync, rst=1 at edge): all outputs 0 except in_ready=1; HI=LO=0; FSM→IDLE; any in-flight mul/div is abandoned.
- Handshake: accept when in_valid & in_ready. No backpressure; out_valid is a single-cycle pulse. in_valid while busy is ignored, so the requester must hold it.
- FSM states:
  - IDLE: accept. Single-cycle op → DONE. mult/div → ITER.
  - ITER: WIDTH iterations, one bit per cycle → FIX.
  - FIX: signed correction, write HI/LO → DONE.
  - DONE: pulse out_valid → IDLE. in_ready=1 only in IDLE.
- Latency:
  - Single-cycle ops: out_valid on the cycle after accept; back-to-back throughput is 1 op per 2 cycles.
  - mult/multu/div/divu: out_valid WIDTH+2 cycles after accept.
- Ops (funct):
  - 0 sll, 2 srl, 3 sra (arithmetic on signed reg_one), 8 jr (result=reg_one).
  - 32 add, 34 sub, 36 and, 37 or, 38 xor, 39 nor.
  - 42 slt (signed), 43 sltu (unsigned); result = {WIDTH-1 zeros, lt}.
  - 16 mfhi, 18 mflo: result = HI/LO.
  - 17 mthi, 19 mtlo: HI/LO ← reg_one, result=0.
  - 24 mult, 25 multu: {HI,LO} = 2·WIDTH-bit product.
  - 26 div, 27 divu: LO=quotient, HI=remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Other codes: result=0, illegal_f=1, HI/LO unchanged.
- Width rules:
  - add/sub computed at WIDTH+1 bits; carry_f = bit WIDTH. For sub/slt/sltu, carry_f=1 means borrow (reg_one < reg_two unsigned).
  - overflow_f:
    - add: operands same sign, result sign differs.
    - sub/slt: operands differ in sign, result sign ≠ reg_one sign.
  - negative_f = diff_msb ^ overflow_f for add/sub/slt; result msb otherwise.
  - For non-arithmetic ops: overflow_f=carry_f=0.
  - For mul/div: zero_f/negative_f reflect LO; result=LO.
- Boundaries:
  - Divide by zero: HI=dividend, LO=all ones; still WIDTH+2 latency; no flag.
  - div of most-negative by −1: LO=most-negative, HI=0.
  - shamt ≥ WIDTH cannot occur (SHAMT_W bits).
  - mfhi issued after mult sees the new HI, since issue is blocked until DONE.

Optional Feature:
- Macro ALU_MD_DIV_EN.
- Defined: div/divu implemented as above.
- Undefined: divider logic omitted; funct 26/27 are treated as illegal (single-cycle, illegal_f=1, HI/LO unchanged). mult/multu are unaffected.

Decomposition:
- Package alu_pkg:
  - funct code localparams (F_SLL … F_DIVU).
  - FSM state enum.
  - function is_md(op).
- Sub-module alu_md_iter: shift-add multiplier / restoring divider engine.
  - Inputs: start, signed, div_sel, operands.
  - Outputs: magnitude result pair, done pulse after WIDTH cycles.
  - Sign fixup stays in the parent.

Test Plan (WIDTH=32):
- add 0x7FFFFFFF+1 → result 0x80000000, overflow_f=1, negative_f=0, carry_f=0; out_valid 1 cycle after accept.
- sub 5−7, then slt 5,7, then sltu 0xFFFFFFFF,1 → 0xFFFFFFFE with carry_f=1 and negative_f=1; slt gives 1; sltu gives 0.
- mult −3×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB, out_valid exactly 34 cycles after accept, in_ready low throughout; then mfhi returns 0xFFFFFFFF.
- div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 → HI=7, LO=0xFFFFFFFF. Without ALU_MD_DIV_EN: illegal_f=1, HI/LO unchanged.
- rst asserted at iteration 10 of multu → next cycle in_ready=1, HI=LO=0, no out_valid pulse.
- op=1 (illegal) → result 0, illegal_f=1; sra 0x80000000 by 4 → 0xF8000000.
